// File: rtl/pipe_alu_pkg.sv
// Shared ALU definitions: func codes, field widths and the packed instruction
// and scoreboard payloads used by the issue controller.
package pipe_alu_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned FUNC_W    = 4;

    typedef enum logic [FUNC_W-1:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        MUL   = 4'd2,
        PASSA = 4'd3,
        PASSB = 4'd4,
        LAND  = 4'd5,
        LOR   = 4'd6,
        LXOR  = 4'd7,
        LNOTA = 4'd8,
        LNOTB = 4'd9,
        SHR   = 4'd10,
        SHL   = 4'd11
    } alu_func_e;

    // 25-bit instruction as carried through the issue buffer
    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [FUNC_W-1:0]    func;
        logic [ADDR_W-1:0]    addr;
        logic                 write;
    } instr_t;

    typedef struct packed {
        logic                 v;
        logic [REG_IDX_W-1:0] rd;
    } sb_entry_t;

    function automatic logic func_legal(input logic [FUNC_W-1:0] func,
                                        input int unsigned       num_ops);
        return 32'(func) < num_ops;
    endfunction

endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// Instruction-in / issue-out bundle of the issue controller.
// master = instruction source and pipeline sink, slave = pipe_issue_ctrl.
interface pipe_issue_ctrl_if;
    import pipe_alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [REG_IDX_W-1:0] in_rs1;
    logic [REG_IDX_W-1:0] in_rs2;
    logic [REG_IDX_W-1:0] in_rd;
    logic [FUNC_W-1:0]    in_func;
    logic [ADDR_W-1:0]    in_addr;
    logic                 in_write;
    logic                 hold;
    logic                 flush;

    logic                 iss_valid;
    logic [REG_IDX_W-1:0] iss_rs1;
    logic [REG_IDX_W-1:0] iss_rs2;
    logic [REG_IDX_W-1:0] iss_rd;
    logic [FUNC_W-1:0]    iss_func;
    logic [ADDR_W-1:0]    iss_addr;
    logic                 iss_write;
    logic                 err_illegal;
    logic                 busy;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, in_write,
        output hold, flush,
        input  in_ready,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, iss_write,
        input  err_illegal, busy
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, in_write,
        input  hold, flush,
        output in_ready,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, iss_write,
        output err_illegal, busy
    );

endinterface

// File: rtl/pipe_issue_fifo.sv
// Synchronous instruction FIFO with wrap-bit pointers and a synchronous flush.
module pipe_issue_fifo
    import pipe_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  instr_t wdata,
    output logic   full,
    output logic   empty,
    output instr_t head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    instr_t        mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointers run modulo 2*DEPTH; flush drops every stored entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_ok);
            rd_ptr <= rd_ptr + PW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller / RAW hazard scheduler in front of the 4-stage ALU pipeline.
// Optional PIPE_ISSUE_PERF_EN adds saturating issue and stall counters.
module pipe_issue_ctrl
    import pipe_alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WB_LAT     = 3,
    parameter int unsigned NUM_OPS    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_issue_ctrl_if.slave  bus
`ifdef PIPE_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall
`endif
);

    instr_t    in_instr;
    instr_t    head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push_c;
    logic      pop_c;
    logic      head_valid_c;
    logic      illegal_c;
    logic      hazard_c;
    logic      issue_c;
    logic      drop_c;
    logic      sb_any_c;
    sb_entry_t sb [WB_LAT];

    instr_t    iss_q;
    logic      iss_valid_q;
    logic      err_illegal_q;

    assign in_instr = '{rs1:   bus.in_rs1,
                        rs2:   bus.in_rs2,
                        rd:    bus.in_rd,
                        func:  bus.in_func,
                        addr:  bus.in_addr,
                        write: bus.in_write};

    assign bus.in_ready = !fifo_full && !bus.flush;
    assign push_c       = bus.in_valid && bus.in_ready;

    pipe_issue_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .flush (bus.flush),
        .wdata (in_instr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Source operands against every in-flight destination; rd-vs-rd is safe
    always_comb begin
        hazard_c = 1'b0;
        sb_any_c = 1'b0;
        for (int i = 0; i < int'(WB_LAT); i++) begin
            if (sb[i].v) begin
                sb_any_c = 1'b1;
                if ((sb[i].rd == head.rs1) || (sb[i].rd == head.rs2)) begin
                    hazard_c = 1'b1;
                end
            end
        end
    end

    assign head_valid_c = !fifo_empty;
    assign illegal_c    = !func_legal(head.func, NUM_OPS);
    assign issue_c      = head_valid_c && !illegal_c && !hazard_c && !bus.hold && !bus.flush;
    assign drop_c       = head_valid_c && illegal_c && !bus.flush;
    assign pop_c        = issue_c || drop_c;

    // Scoreboard drains every cycle, independent of hold and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WB_LAT); i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= '{v: issue_c, rd: head.rd};
            for (int i = 1; i < int'(WB_LAT); i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // Issue register: payload holds across bubbles, write strobe does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q         <= '0;
            iss_valid_q   <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            iss_valid_q   <= issue_c;
            err_illegal_q <= drop_c;
            if (issue_c) begin
                iss_q <= head;
            end else begin
                iss_q.write <= 1'b0;
            end
        end
    end

    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_rs1     = iss_q.rs1;
    assign bus.iss_rs2     = iss_q.rs2;
    assign bus.iss_rd      = iss_q.rd;
    assign bus.iss_func    = iss_q.func;
    assign bus.iss_addr    = iss_q.addr;
    assign bus.iss_write   = iss_q.write;
    assign bus.err_illegal = err_illegal_q;
    assign bus.busy        = head_valid_c || sb_any_c;

`ifdef PIPE_ISSUE_PERF_EN
    logic stall_c;

    assign stall_c = head_valid_c && !illegal_c && !bus.hold && hazard_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue_c && (perf_issued != '1)) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (stall_c && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
Issue controller and hazard scheduler in front of the 4-stage pipelined ALU. It buffers incoming ALU instructions in a small FIFO and tracks in-flight destination registers in a scoreboard. It issues one instruction per cycle to the pipeline's rs1/rs2/rd/func/addr/write inputs, inserting bubbles on read-after-write hazards so no instruction reads a register bank entry before the older write lands.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries; power of 2, at least 2
WB_LAT, 3, cycles from an issue edge until that result is readable from the register bank
NUM_OPS, 12, legal func codes are 0..NUM_OPS-1

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  FIFO can accept
in_rs1, in_rs2, in_rd  in  4 each  register indices
in_func  in  4  ALU op code
in_addr  in  8  memory address
in_write  in  1  memory write enable
hold  in  1  downstream freeze; blocks issue
flush  in  1  synchronous FIFO discard
iss_valid  out  1  issue strobe; pipeline inputs valid this cycle
iss_rs1, iss_rs2, iss_rd, iss_func  out  4 each  to pipeline
iss_addr  out  8  to pipeline
iss_write  out  1  to pipeline; 0 whenever iss_valid=0
err_illegal  out  1  one-cycle pulse when an illegal func is dropped
busy  out  1  FIFO non-empty or any scoreboard entry valid

Behaviour:
- Reset (rst_n=0, async): FIFO empty, scoreboard cleared, all iss_* = 0, err_illegal = 0, in_ready = 1 once reset is released. Reset mid-stream discards everything; nothing issues until after release.
- Push: occurs when in_valid && in_ready. in_ready = !full && !flush, so a simultaneous push into a full FIFO is impossible.
- Simultaneous pop and push on a full FIFO is legal only as a pop followed by a later push, because in_ready is computed from the current full flag.
- Head checks each cycle: illegal (func >= NUM_OPS), hazard (head rs1 or rs2 equals the rd of any valid scoreboard entry), or issuable.
- Issue condition: head valid && !hazard && !illegal && !hold && !flush. The head pops, and the registered iss_* outputs update on that edge, so latency from a push into an empty FIFO to iss_valid is 1 cycle.
- Illegal head: popped without issue even if hold=1. err_illegal pulses for 1 cycle. iss_valid = 0 that cycle.
- Bubble (no issue): iss_valid = 0, iss_write = 0; the other iss_* hold their last values.
- Scoreboard:
  - Shift register of WB_LAT entries {v, rd}, shifting every cycle regardless of hold.
  - Entry 0 loads {1, iss_rd} on an issue, otherwise {0, x}.
  - A dependent instruction therefore issues exactly WB_LAT+1 edges after its producer, with WB_LAT bubbles between them.
- Hazard compare covers rs1 and rs2 against all entries; rd-vs-rd (WAW) is not a hazard because writes retire in order. Register 0 is not special.
- Flush: clears the FIFO only. The scoreboard keeps draining so in-flight writes stay protected. Flush wins over push and issue in the same cycle.
- hold=1 with a hazard: nothing issues, and the scoreboard still drains.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. full = MSBs differ and low bits equal.

Optional Feature:
PIPE_ISSUE_PERF_EN
- Defined: adds outputs perf_issued[31:0] and perf_stall[31:0].
  - perf_issued counts issue edges.
  - perf_stall counts cycles with head valid, legal, !hold, and hazard asserted.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_alu_pkg:
  - func code constants: ADD=0, SUB=1, MUL=2, PASSA=3, PASSB=4, LAND=5, LOR=6, LXOR=7, LNOTA=8, LNOTB=9, SHR=10, SHL=11
  - REG_IDX_W=4, ADDR_W=8
  - packed instruction struct {rs1, rs2, rd, func, addr, write} (25 bits)
- Sub-module pipe_issue_fifo: parameterised synchronous FIFO storing that struct, with push, pop, flush, full, empty, and a head output.

Test Plan:
1. Reset mid-stream: push 3 instructions, pulse rst_n low for 1 cycle → iss_valid=0, busy=0, in_ready=1; no stale issue afterwards.
2. Independent stream: push {rd=1,rs=2,3}, {rd=4,rs=5,6}, {rd=7,rs=8,9}, {rd=10,rs=11,12} back-to-back → 4 consecutive iss_valid cycles starting 1 cycle after the first push, with fields in order.
3. RAW hazard, WB_LAT=3: I0 {rd=3}, I1 {rs1=3} → I1 issues 4 edges after I0, with 3 bubbles (iss_write=0); perf_stall=3 when PIPE_ISSUE_PERF_EN is defined.
4. Full FIFO: hold=1, offer 5 instructions → in_ready=0 after the 4th push; release hold → all 4 issue and in_ready returns to 1.
5. Illegal op: head func=12, next func=0 → err_illegal pulses once, no issue for func 12, func 0 issues the following cycle.
6. Flush during hazard: I0 {rd=5}, then queue I1 {rs2=5} and I2, assert flush → FIFO empties, busy stays 1 until the scoreboard drains (3 cycles), no issue of I1 or I2.
